// File: rtl/ps2_keyboard_tx_if.sv
// Byte hand-off between a scan-code producer and the PS/2 transmitter.
// The producer drives tx_valid/tx_data; the transmitter answers with tx_ready.
interface ps2_keyboard_tx_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;

  modport master (output tx_valid, output tx_data, input tx_ready);
  modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/ps2_keyboard_tx.sv
// Device-side PS/2 transmitter: queues scan-code bytes in a small FIFO and
// replays each one as an 11-bit device-to-host frame (start, 8 data LSB first,
// odd parity, stop) on registered ps2_clk/ps2_data lines, followed by an idle gap.
module ps2_keyboard_tx #(
  parameter int HALF_PERIOD = 8,
  parameter int GAP_CYCLES  = 16,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          resetn,
  ps2_keyboard_tx_if.slave              tx,
  output logic                          ps2_clk,
  output logic                          ps2_data,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PW      = $clog2(FIFO_DEPTH) + 1;
  localparam int AW      = PW - 1;
  localparam int CNT_MAX = (HALF_PERIOD > GAP_CYCLES) ? HALF_PERIOD : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX) + 1;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW,
    GAP
  } state_t;

  // FIFO storage and pointers (one extra wrap bit to tell full from empty)
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          not_empty_q;
  logic [7:0]    head;

  // Serializer state
  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic [3:0]    bit_idx;
  logic [3:0]    bit_idx_next;
  logic [10:0]   frame;
  logic [10:0]   frame_next;
  logic          ps2_clk_next;
  logic          ps2_data_next;
  logic          busy_next;

  assign full       = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty      = (wr_ptr == rd_ptr);
  assign tx.tx_ready = !full;
  assign push       = tx.tx_valid && !full;
  assign fifo_count = wr_ptr - rd_ptr;
  assign head       = mem[rd_ptr[AW-1:0]];

  // Byte storage; contents need no reset because the pointers define validity
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= tx.tx_data;
    end
  end

  // FIFO pointers; reset flushes the queue by equalising them
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Registered non-empty flag gives the idle state one clock to notice a new byte
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      not_empty_q <= 1'b0;
    end else begin
      not_empty_q <= !empty;
    end
  end

  // Serializer state and line registers; reset drives the lines high at once
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      frame    <= '1;
      ps2_clk  <= 1'b1;
      ps2_data <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      bit_idx  <= bit_idx_next;
      frame    <= frame_next;
      ps2_clk  <= ps2_clk_next;
      ps2_data <= ps2_data_next;
      busy     <= busy_next;
    end
  end

  // Next-state logic: phase timing, bit stepping, and the values the lines take next
  always_comb begin
    state_next    = state;
    cnt_next      = cnt + 1'b1;
    bit_idx_next  = bit_idx;
    frame_next    = frame;
    pop           = 1'b0;

    case (state)
      IDLE: begin
        cnt_next = '0;
        if (not_empty_q && !empty) begin
          pop          = 1'b1;
          frame_next   = {1'b1, ~^head, head, 1'b0};
          bit_idx_next = 4'd0;
          state_next   = HIGH;
        end
      end
      HIGH: begin
        if (cnt == CW'(HALF_PERIOD - 1)) begin
          state_next = LOW;
        end
      end
      LOW: begin
        if (cnt == CW'(HALF_PERIOD - 1)) begin
          if (bit_idx == 4'd10) begin
            state_next = GAP;
          end else begin
            bit_idx_next = bit_idx + 4'd1;
            frame_next   = {1'b1, frame[10:1]};
            state_next   = HIGH;
          end
        end
      end
      GAP: begin
        if (cnt == CW'(GAP_CYCLES - 1)) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (state_next != state) begin
      cnt_next = '0;
    end

    ps2_clk_next = (state_next != LOW);
    busy_next    = (state_next != IDLE);
    if (state_next == HIGH) begin
      ps2_data_next = frame_next[0];
    end else if (state_next == LOW) begin
      ps2_data_next = ps2_data;
    end else begin
      ps2_data_next = 1'b1;
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_tx.sv
// Directed bench for ps2_keyboard_tx: drives bytes through the interface,
// queues the expected bytes, and decodes the PS/2 lines on falling ps2_clk
// edges to compare each recovered frame against the queue.
module tb_ps2_keyboard_tx;

  localparam int HP    = 8;
  localparam int GAP   = 16;
  localparam int DEPTH = 4;
  localparam int PITCH = 22 * HP + GAP + 1;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       ps2_clk;
  logic       ps2_data;
  logic       busy;
  logic [2:0] fifo_count;

  int n_compared   = 0;
  int n_mismatched = 0;
  int cyc          = 0;

  logic [7:0] exp_q[$];
  int         start_q[$];
  int         frames_done = 0;
  int         bitcnt = 0;
  int         last_fall = 0;
  logic [10:0] cap = '0;

  ps2_keyboard_tx_if txif ();

  ps2_keyboard_tx #(
    .HALF_PERIOD (HP),
    .GAP_CYCLES  (GAP),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .tx         (txif),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  // 10 ns system clock
  always #5 clk = ~clk;

  // Rising-edge counter used as the time base for latency and pitch checks
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_compared++;
    assert (observed === expected) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Line decoder: samples data on each ps2_clk fall and scores complete frames
  initial forever begin
    logic [7:0] e;
    @(negedge ps2_clk or negedge resetn);
    if (!resetn) begin
      bitcnt = 0;
    end else begin
      if (bitcnt > 0) begin
        checkOutput("bit_period", cyc - last_fall, 2 * HP);
      end else begin
        start_q.push_back(cyc);
      end
      last_fall = cyc;
      cap = {ps2_data, cap[10:1]};
      bitcnt++;
      if (bitcnt == 11) begin
        bitcnt = 0;
        frames_done++;
        if (exp_q.size() == 0) begin
          checkOutput("frame_expected", exp_q.size(), 32'd1);
        end else begin
          e = exp_q.pop_front();
          checkOutput("frame_bits", 32'(cap), 32'({1'b1, ~^e, e, 1'b0}));
          checkOutput("odd_parity", 32'(^cap[9:1]), 32'd1);
        end
      end
    end
  end

  // Offer one byte for one rising edge; accept says whether the bench expects it taken
  task automatic applyStimulus(input logic [7:0] b, input bit accept);
    checkOutput("tx_ready", 32'(txif.tx_ready), 32'(accept));
    txif.tx_valid = 1'b1;
    txif.tx_data  = b;
    if (accept) exp_q.push_back(b);
    @(posedge clk);
    #1;
    txif.tx_valid = 1'b0;
    txif.tx_data  = 8'h00;
  endtask

  // Advance to the falling clock edge that follows rising edge number n
  task automatic waitEdge(input int n);
    int guard = 0;
    @(negedge clk);
    while (cyc < n && guard < 100000) begin
      @(negedge clk);
      guard++;
    end
  endtask

  task automatic waitFrames(input int n, input int budget);
    int k = 0;
    while (frames_done < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    checkOutput("frame_count", frames_done, n);
  endtask

  task automatic waitIdle();
    int k = 0;
    @(negedge clk);
    while (busy && k < 1000) begin
      @(negedge clk);
      k++;
    end
    checkOutput("idle_reached", 32'(busy), 32'd0);
  endtask

  // Push into an idle transmitter and check when the frame first shows on the lines
  task automatic checkLatency(input logic [7:0] b);
    int t;
    applyStimulus(b, 1'b1);
    t = cyc;
    waitEdge(t + 1);
    checkOutput("lat_data_t1", 32'(ps2_data), 32'd1);
    checkOutput("lat_busy_t1", 32'(busy), 32'd0);
    waitEdge(t + 2);
    checkOutput("lat_data_t2", 32'(ps2_data), 32'd0);
    checkOutput("lat_busy_t2", 32'(busy), 32'd1);
    checkOutput("lat_count_t2", 32'(fifo_count), 32'd0);
    waitEdge(t + 2 + HP - 1);
    checkOutput("lat_clk_high", 32'(ps2_clk), 32'd1);
    waitEdge(t + 2 + HP);
    checkOutput("lat_clk_low", 32'(ps2_clk), 32'd0);
    if (start_q.size() > 0) checkOutput("first_fall", start_q[$], t + 2 + HP);
    else checkOutput("first_fall_seen", start_q.size(), 32'd1);
  endtask

  initial begin
    int t;
    int f;
    txif.tx_valid = 1'b0;
    txif.tx_data  = 8'h00;
    resetn        = 1'b0;

    $display("[TB] reset values");
    repeat (3) @(negedge clk);
    checkOutput("rst_ps2_clk", 32'(ps2_clk), 32'd1);
    checkOutput("rst_ps2_data", 32'(ps2_data), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_tx_ready", 32'(txif.tx_ready), 32'd1);
    checkOutput("rst_fifo_count", 32'(fifo_count), 32'd0);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] single byte 1C with latency and gap timing");
    checkLatency(8'h1C);
    t = start_q[$] - HP;
    waitEdge(t + 22 * HP + GAP - 1);
    checkOutput("busy_gap_end", 32'(busy), 32'd1);
    checkOutput("gap_clk_high", 32'(ps2_clk), 32'd1);
    waitEdge(t + 22 * HP + GAP);
    checkOutput("busy_fall", 32'(busy), 32'd0);
    checkOutput("frames_after_1c", frames_done, 32'd1);

    $display("[TB] back-to-back F0 1C");
    f = frames_done;
    applyStimulus(8'hF0, 1'b1);
    t = cyc;
    applyStimulus(8'h1C, 1'b1);
    waitEdge(t + 2);
    checkOutput("count_between_pops", 32'(fifo_count), 32'd1);
    waitFrames(f + 2, 3 * PITCH);
    if (start_q.size() >= 2) checkOutput("frame_pitch", start_q[$] - start_q[$-1], PITCH);
    else checkOutput("frame_pitch_seen", start_q.size(), 32'd2);
    waitIdle();

    $display("[TB] parity patterns 00 FF 01");
    f = frames_done;
    applyStimulus(8'h00, 1'b1);
    applyStimulus(8'hFF, 1'b1);
    applyStimulus(8'h01, 1'b1);
    waitFrames(f + 3, 4 * PITCH);
    waitIdle();

    $display("[TB] fill the queue while busy");
    f = frames_done;
    applyStimulus(8'hA0, 1'b1);
    t = cyc;
    waitEdge(t + 3);
    applyStimulus(8'hA1, 1'b1);
    applyStimulus(8'hA2, 1'b1);
    applyStimulus(8'hA3, 1'b1);
    applyStimulus(8'hA4, 1'b1);
    applyStimulus(8'hA5, 1'b0);
    @(negedge clk);
    checkOutput("full_count", 32'(fifo_count), 32'd4);
    checkOutput("full_ready", 32'(txif.tx_ready), 32'd0);
    waitFrames(f + 5, 6 * PITCH);
    waitIdle();
    waitEdge(cyc + PITCH);
    checkOutput("no_extra_frame", frames_done, f + 5);
    checkOutput("queue_drained", exp_q.size(), 32'd0);

    $display("[TB] reset during data bit 4");
    applyStimulus(8'hC0, 1'b1);
    t = cyc;
    applyStimulus(8'hC1, 1'b1);
    applyStimulus(8'hC2, 1'b1);
    waitEdge(t + 2 + 10 * HP + 3);
    checkOutput("pre_rst_data", 32'(ps2_data), 32'd0);
    checkOutput("pre_rst_count", 32'(fifo_count), 32'd2);
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("midrst_ps2_clk", 32'(ps2_clk), 32'd1);
    checkOutput("midrst_ps2_data", 32'(ps2_data), 32'd1);
    checkOutput("midrst_count", 32'(fifo_count), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    exp_q.delete();
    start_q.delete();
    f = frames_done;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    waitEdge(cyc + 3 * PITCH);
    checkOutput("post_rst_frames", frames_done, f);
    checkOutput("post_rst_data", 32'(ps2_data), 32'd1);
    checkOutput("post_rst_busy", 32'(busy), 32'd0);

    $display("[TB] fresh push 5A after reset");
    checkLatency(8'h5A);
    waitFrames(f + 1, 2 * PITCH);
    waitIdle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
